// File: rtl/div_unit_pkg.sv
// Shared definitions for the mult/div unit: controller state encoding,
// default datapath width and the most negative operand value.
package div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [WIDTH_DEF-1:0] INT_MIN = 32'h8000_0000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/div_unit_if.sv
// Start/ready handshake and operand/result bus shared by the divider and the
// Booth multiplier. The processor's stall logic sits on the master side.
interface div_unit_if #(
  parameter int WIDTH = 32
);

  logic                    ctrl_DIV;
  logic signed [WIDTH-1:0] data_operandA;
  logic signed [WIDTH-1:0] data_operandB;
  logic signed [WIDTH-1:0] data_result;
  logic signed [WIDTH-1:0] data_remainder;
  logic                    data_exception;
  logic                    data_resultRDY;
  logic                    busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes: shift the
// next dividend bit into the partial remainder and subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // rem < divisor <= 2^(WIDTH-1), so a WIDTH+1 bit trial never overflows.
  logic [WIDTH:0] trial;

  assign trial    = {rem, q_msb} - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], q_msb};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient
// bit per clock, followed by a single sign-fix cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sign_quo_q, sign_quo_d;
  logic               sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] mag,
                                                input logic neg);
    return neg ? (WIDTH'(0) - mag) : mag;
  endfunction

  // INT_MIN maps onto its own bit pattern, read back as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return fix_sign(v, v[WIDTH-1]);
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q_msb    (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    sign_quo_d  = sign_quo_q;
    sign_rem_d  = sign_rem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    rdy_d       = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d    = fix_sign(quo_q, sign_quo_q);
        remainder_d = fix_sign(rem_q, sign_rem_q);
        rdy_d       = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      ST_DONE: begin
        // A restart on this edge aborts the divide-by-zero report entirely.
        if (!bus.ctrl_DIV) begin
          result_d    = '0;
          remainder_d = fix_sign(quo_q, sign_rem_q);
          exc_d       = 1'b1;
          rdy_d       = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A start wins over any in-flight work; a FIX completion on the same edge still reports.
    if (bus.ctrl_DIV) begin
      quo_d      = magnitude(bus.data_operandA);
      rem_d      = '0;
      dvs_d      = magnitude(bus.data_operandB);
      sign_quo_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      sign_rem_d = bus.data_operandA[WIDTH-1];
      cnt_d      = '0;
      exc_d      = 1'b0;
      busy_d     = 1'b1;
      state_d    = (bus.data_operandB == '0) ? ST_DONE : ST_RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      sign_quo_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      sign_quo_q  <= sign_quo_d;
      sign_rem_q  <= sign_rem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = remainder_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed results, divide-by-zero,
// INT_MIN corner cases, abort/restart, FIX-edge restart and mid-run reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   rdy_cnt;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.data_resultRDY) rdy_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(input int max, output int edges);
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
    end while (!bus.data_resultRDY && edges < max);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ee, input int elat);
    int lat;
    issue(a, b);
    chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    wait_rdy(40, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, bus.data_result, eq);
    chk({tag, "_r"}, bus.data_remainder, er);
    chk({tag, "_exc"}, 32'(bus.data_exception), 32'(ee));
    chk({tag, "_busy_at_rdy"}, 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
    chk({tag, "_rdy_pulse"}, 32'(bus.data_resultRDY), 32'd0);
    chk({tag, "_hold_q"}, bus.data_result, eq);
  endtask

  initial begin
    int lat;
    int base;
    errors = 0;
    checks = 0;
    rdy_cnt = 0;
    reset = 1'b1;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_q", bus.data_result, 32'd0);
    chk("rst_r", bus.data_remainder, 32'd0);
    chk("rst_exc", 32'(bus.data_exception), 32'd0);
    chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_div("pos",    32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    run_div("negA",   32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33);
    run_div("negB",   32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33);
    run_div("div0",   32'd5,          32'd0,          32'd0,          32'd5,          1'b1, 1);
    run_div("div0n",  32'hFFFF_FFFB,  32'd0,          32'd0,          32'hFFFF_FFFB,  1'b1, 1);
    run_div("excclr", 32'd7,          32'hFFFF_FF9C,  32'd0,          32'd7,          1'b0, 33);
    run_div("ovf",    INT_MIN,        32'hFFFF_FFFF,  INT_MIN,        32'd0,          1'b0, 33);
    run_div("min2",   INT_MIN,        32'd2,          32'hC000_0000,  32'd0,          1'b0, 33);

    // Restart at edge +10 aborts the first divide.
    base = rdy_cnt;
    issue(32'd100, 32'd7);
    repeat (9) begin @(posedge clock); #1; end
    issue(32'd81, 32'd9);
    wait_rdy(40, lat);
    chk("abort_latency", 32'(lat), 32'd33);
    chk("abort_q", bus.data_result, 32'd9);
    chk("abort_r", bus.data_remainder, 32'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("abort_pulses", 32'(rdy_cnt - base), 32'd1);

    // Restart on the FIX edge: old result still reported, new one follows.
    issue(32'd100, 32'd7);
    repeat (32) begin @(posedge clock); #1; end
    issue(32'd81, 32'd9);
    chk("fixrs_rdy", 32'(bus.data_resultRDY), 32'd1);
    chk("fixrs_q", bus.data_result, 32'd14);
    chk("fixrs_r", bus.data_remainder, 32'd2);
    chk("fixrs_busy", 32'(bus.busy), 32'd1);
    wait_rdy(40, lat);
    chk("fixrs_latency", 32'(lat), 32'd33);
    chk("fixrs_q2", bus.data_result, 32'd9);

    // Reset mid-run at edge +15.
    issue(32'd100, 32'd7);
    repeat (14) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mrst_q", bus.data_result, 32'd0);
    chk("mrst_r", bus.data_remainder, 32'd0);
    chk("mrst_exc", 32'(bus.data_exception), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_rdy", 32'(bus.data_resultRDY), 32'd0);
    base = rdy_cnt;
    repeat (40) @(posedge clock);
    #1;
    chk("mrst_no_pulse", 32'(rdy_cnt - base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
